bram_bank_arbiter: RTL and testbench
====================================

BRAM_BANK_ARBITER -- requirements
Module: bram_bank_arbiter

Interface
- REQ-001: Parameter BANKS, default 4: number of BRAM banks; SHALL be a power of 2, ≥2.
- REQ-002: Parameter DATA_WIDTH, default 16: bank word width; SHALL be a multiple of 8.
- REQ-003: Parameter OUT_DEPTH, default 256: words per bank; SHALL be a power of 2.
- REQ-004: Parameter RD_LAT, default 1: bank read latency in cycles; SHALL be 1..4.
- REQ-005: Derived constants: BANK_BITS=LOG2(BANKS), OUT_ADDR=LOG2(OUT_DEPTH), IN_ADDR=OUT_ADDR+BANK_BITS, WE=DATA_WIDTH/8.
- REQ-006: Clock and reset: one clock; reset is synchronous and active-high.
- REQ-007: clk  in  1  sole clock; all state updates on rising edge.
- REQ-008: rst  in  1  synchronous active-high reset.
- REQ-009: a_req_valid/a_req_ready  in/out  1  requester A (host) handshake.
- REQ-010: a_req_addr  in  IN_ADDR  word address; a_req_we  in  WE  byte write-enables; a_req_wrdata  in  DATA_WIDTH.
- REQ-011: a_rsp_valid  out  1; a_rsp_rddata  out  DATA_WIDTH  read response to A.
- REQ-012: b_* SHALL mirror REQ-009..011 for requester B (compute engine).
- REQ-013: bram_en  out  BANKS; bram_we  out  BANKS*WE; bram_addr  out  BANKS*OUT_ADDR; bram_wrdata  out  BANKS*DATA_WIDTH; bram_rddata  in  BANKS*DATA_WIDTH; bank i occupies slice i, LSB first.
- REQ-014: conflict_cnt  out  16  saturating count of same-bank collisions.

Function
- REQ-015: Bank decode: bank = addr[BANK_BITS-1:0]; bank address = addr[IN_ADDR-1:BANK_BITS] (low-order interleaving).
- REQ-016: A request is accepted in the cycle where valid && ready; ready SHALL be combinational from the arbitration result, with no bubble.
- REQ-017: Different target banks: both requesters SHALL be granted in the same cycle.
- REQ-018: Same target bank (conflict): the winner is the requester indicated by priority register prio (0=A, 1=B); the loser's ready is 0.
- REQ-019: After a conflict grant, prio SHALL flip to the loser; without a conflict, prio SHALL hold. Worst-case wait is therefore 1 cycle.
- REQ-020: A single valid requester SHALL be granted unconditionally.
- REQ-021: Granted bank: bram_en[bank]=1, bram_addr/we/wrdata slices driven from the winner in the same cycle; non-granted banks: en=0, we=0, addr/wrdata=0.
- REQ-022: A read (we==0) accepted at cycle T SHALL produce rsp_valid=1 for exactly one cycle at T+RD_LAT, with rsp_rddata = bram_rddata slice of the bank recorded at T.
- REQ-023: A write (we≠0) SHALL produce no response; partial byte-enables pass through unchanged.
- REQ-024: Per requester, an RD_LAT-deep pipeline of {valid, bank} SHALL track reads; back-to-back reads SHALL yield back-to-back responses in issue order.
- REQ-025: Responses have no backpressure; requesters SHALL always accept them.
- REQ-026: conflict_cnt increments by 1 on each cycle with both valid and equal banks; it saturates at 0xFFFF.
- REQ-027: rsp_rddata SHALL be 0 when rsp_valid=0.

Reset
- REQ-028: While rst=1: a_req_ready=b_req_ready=0, all bram_* outputs 0, rsp_valid=0, rsp_rddata=0.
- REQ-029: Reset SHALL set prio=0 (A first), clear both read pipelines, and set conflict_cnt=0; reads in flight are discarded with no response.
- REQ-030: The first cycle after rst deasserts SHALL arbitrate normally.

Structure
- REQ-031: A shared package/header SHALL hold LOG2, BANK_BITS/OUT_ADDR derivation and the prio encoding (PRIO_A=0, PRIO_B=1).
- REQ-032: The read-tracking pipeline SHALL be a sub-module rd_tag_pipe (params RD_LAT, BANK_BITS), instantiated once per requester.

Verification
- REQ-033: A reads addr 0x005, B reads addr 0x00A, same cycle (banks 1, 2) -> both ready=1, bram_en=4'b0110, both rsp_valid at T+RD_LAT with the correct bank data.
- REQ-034: A and B both read bank 3 for 4 consecutive cycles -> grants alternate A,B,A,B; conflict_cnt=4; each requester waits at most 1 cycle.
- REQ-035: A writes 0xBEEF to addr 0x010 with we=2'b01 -> bram_en[0]=1, bram_we bank0=2'b01, bram_addr bank0=0x04; no a_rsp_valid.
- REQ-036: rst asserted one cycle after a read is accepted with RD_LAT=2 -> no rsp_valid appears; prio=A and conflict_cnt=0 after reset.
- REQ-037: Force 70000 conflicts -> conflict_cnt holds at 0xFFFF.
- REQ-038: A streams reads to addr 0..7 with RD_LAT=3 -> 8 consecutive rsp_valid cycles, data in address order.

Source files
------------

// File: rtl/bram_bank_arbiter_pkg.sv
`default_nettype none
//============================================================================
// Module      : bram_bank_arbiter_pkg
// Description : Shared width helper and priority encoding for the bank arbiter.
// Revision    : 1.0 - initial release
//============================================================================
package bram_bank_arbiter_pkg;

    // Ceiling log2, usable in parameter elaboration.
    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int bank_bits_f(input int banks);
        return log2_ceil(banks);
    endfunction

    function automatic int out_addr_f(input int out_depth);
        return log2_ceil(out_depth);
    endfunction

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

endpackage : bram_bank_arbiter_pkg
`default_nettype wire

// File: rtl/bram_bank_arbiter_rd_tag_pipe.sv
`default_nettype none
//============================================================================
// Module      : rd_tag_pipe
// Description : Delay line of {valid, bank} tags matching the bank read latency.
// Revision    : 1.0 - initial release
//============================================================================
module rd_tag_pipe #(
    parameter int RD_LAT    = 1,
    parameter int BANK_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [BANK_BITS-1:0] bank_i,
    output logic                 valid_o,
    output logic [BANK_BITS-1:0] bank_o
);

    logic [RD_LAT-1:0]    valid_q;
    logic [BANK_BITS-1:0] bank_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= push_i;
            bank_q[0]  <= bank_i;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                bank_q[i]  <= bank_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[RD_LAT-1];
    assign bank_o  = bank_q[RD_LAT-1];

endmodule : rd_tag_pipe
`default_nettype wire

// File: rtl/bram_bank_arbiter.sv
`default_nettype none
//============================================================================
// Module      : bram_bank_arbiter
// Description : Two-requester arbiter onto low-order interleaved BRAM banks.
// Revision    : 1.0 - initial release
//============================================================================
module bram_bank_arbiter
    import bram_bank_arbiter_pkg::*;
#(
    parameter int  BANKS      = 4,
    parameter int  DATA_WIDTH = 16,
    parameter int  OUT_DEPTH  = 256,
    parameter int  RD_LAT     = 1,
    localparam int BANK_BITS  = bank_bits_f(BANKS),
    localparam int OUT_ADDR   = out_addr_f(OUT_DEPTH),
    localparam int IN_ADDR    = OUT_ADDR + BANK_BITS,
    localparam int WE         = DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic                           a_req_valid_i,
    output logic                           a_req_ready_o,
    input  logic [IN_ADDR-1:0]             a_req_addr_i,
    input  logic [WE-1:0]                  a_req_we_i,
    input  logic [DATA_WIDTH-1:0]          a_req_wrdata_i,
    output logic                           a_rsp_valid_o,
    output logic [DATA_WIDTH-1:0]          a_rsp_rddata_o,

    input  logic                           b_req_valid_i,
    output logic                           b_req_ready_o,
    input  logic [IN_ADDR-1:0]             b_req_addr_i,
    input  logic [WE-1:0]                  b_req_we_i,
    input  logic [DATA_WIDTH-1:0]          b_req_wrdata_i,
    output logic                           b_rsp_valid_o,
    output logic [DATA_WIDTH-1:0]          b_rsp_rddata_o,

    output logic [BANKS-1:0]               bram_en_o,
    output logic [BANKS*WE-1:0]            bram_we_o,
    output logic [BANKS*OUT_ADDR-1:0]      bram_addr_o,
    output logic [BANKS*DATA_WIDTH-1:0]    bram_wrdata_o,
    input  logic [BANKS*DATA_WIDTH-1:0]    bram_rddata_i,

    output logic [15:0]                    conflict_cnt_o
);

    prio_e                prio_q, prio_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [BANK_BITS-1:0] a_bank, b_bank;
    logic                 conflict;
    logic                 a_grant, b_grant;
    logic                 a_tag_valid, b_tag_valid;
    logic [BANK_BITS-1:0] a_tag_bank, b_tag_bank;

    assign a_bank   = a_req_addr_i[BANK_BITS-1:0];
    assign b_bank   = b_req_addr_i[BANK_BITS-1:0];
    assign conflict = a_req_valid_i && b_req_valid_i && (a_bank == b_bank);

    // Grants stay combinational so a request is accepted in the cycle it is seen.
    assign a_grant = !rst && a_req_valid_i && (!conflict || (prio_q == PRIO_A));
    assign b_grant = !rst && b_req_valid_i && (!conflict || (prio_q == PRIO_B));

    assign a_req_ready_o = a_grant;
    assign b_req_ready_o = b_grant;

    always_comb begin
        prio_d = prio_q;
        cnt_d  = cnt_q;
        if (conflict) begin
            prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= PRIO_A;
            cnt_q  <= '0;
        end else begin
            prio_q <= prio_d;
            cnt_q  <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;

    always_comb begin
        bram_en_o     = '0;
        bram_we_o     = '0;
        bram_addr_o   = '0;
        bram_wrdata_o = '0;
        for (int i = 0; i < BANKS; i++) begin
            if (a_grant && (a_bank == BANK_BITS'(i))) begin
                bram_en_o[i]                               = 1'b1;
                bram_we_o[i*WE +: WE]                      = a_req_we_i;
                bram_addr_o[i*OUT_ADDR +: OUT_ADDR]        = a_req_addr_i[IN_ADDR-1:BANK_BITS];
                bram_wrdata_o[i*DATA_WIDTH +: DATA_WIDTH]  = a_req_wrdata_i;
            end else if (b_grant && (b_bank == BANK_BITS'(i))) begin
                bram_en_o[i]                               = 1'b1;
                bram_we_o[i*WE +: WE]                      = b_req_we_i;
                bram_addr_o[i*OUT_ADDR +: OUT_ADDR]        = b_req_addr_i[IN_ADDR-1:BANK_BITS];
                bram_wrdata_o[i*DATA_WIDTH +: DATA_WIDTH]  = b_req_wrdata_i;
            end
        end
    end

    rd_tag_pipe #(
        .RD_LAT    (RD_LAT),
        .BANK_BITS (BANK_BITS)
    ) u_a_tags (
        .clk     (clk),
        .rst     (rst),
        .push_i  (a_grant && (a_req_we_i == '0)),
        .bank_i  (a_bank),
        .valid_o (a_tag_valid),
        .bank_o  (a_tag_bank)
    );

    rd_tag_pipe #(
        .RD_LAT    (RD_LAT),
        .BANK_BITS (BANK_BITS)
    ) u_b_tags (
        .clk     (clk),
        .rst     (rst),
        .push_i  (b_grant && (b_req_we_i == '0)),
        .bank_i  (b_bank),
        .valid_o (b_tag_valid),
        .bank_o  (b_tag_bank)
    );

    // Tags still in the pipe during reset are masked here and flushed at the edge.
    assign a_rsp_valid_o = !rst && a_tag_valid;
    assign b_rsp_valid_o = !rst && b_tag_valid;

    always_comb begin
        a_rsp_rddata_o = '0;
        b_rsp_rddata_o = '0;
        for (int i = 0; i < BANKS; i++) begin
            if (a_rsp_valid_o && (a_tag_bank == BANK_BITS'(i))) begin
                a_rsp_rddata_o = bram_rddata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (b_rsp_valid_o && (b_tag_bank == BANK_BITS'(i))) begin
                b_rsp_rddata_o = bram_rddata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule : bram_bank_arbiter
`default_nettype wire

// File: tb/tb_bram_bank_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : tb_bram_bank_arbiter
// Description : Scoreboard bench with a flat-memory reference and BRAM model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_bram_bank_arbiter;

    localparam int BANKS  = 4;
    localparam int DW     = 16;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 2;
    localparam int OA     = 8;
    localparam int IA     = 10;
    localparam int WEW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             a_req_valid_i  = 1'b0;
    logic             a_req_ready_o;
    logic [IA-1:0]    a_req_addr_i   = '0;
    logic [WEW-1:0]   a_req_we_i     = '0;
    logic [DW-1:0]    a_req_wrdata_i = '0;
    logic             a_rsp_valid_o;
    logic [DW-1:0]    a_rsp_rddata_o;
    logic             b_req_valid_i  = 1'b0;
    logic             b_req_ready_o;
    logic [IA-1:0]    b_req_addr_i   = '0;
    logic [WEW-1:0]   b_req_we_i     = '0;
    logic [DW-1:0]    b_req_wrdata_i = '0;
    logic             b_rsp_valid_o;
    logic [DW-1:0]    b_rsp_rddata_o;
    logic [BANKS-1:0]       bram_en_o;
    logic [BANKS*WEW-1:0]   bram_we_o;
    logic [BANKS*OA-1:0]    bram_addr_o;
    logic [BANKS*DW-1:0]    bram_wrdata_o;
    logic [BANKS*DW-1:0]    bram_rddata_i;
    logic [15:0]            conflict_cnt_o;

    bram_bank_arbiter #(
        .BANKS(BANKS), .DATA_WIDTH(DW), .OUT_DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req_valid_i(a_req_valid_i), .a_req_ready_o(a_req_ready_o),
        .a_req_addr_i(a_req_addr_i), .a_req_we_i(a_req_we_i),
        .a_req_wrdata_i(a_req_wrdata_i), .a_rsp_valid_o(a_rsp_valid_o),
        .a_rsp_rddata_o(a_rsp_rddata_o),
        .b_req_valid_i(b_req_valid_i), .b_req_ready_o(b_req_ready_o),
        .b_req_addr_i(b_req_addr_i), .b_req_we_i(b_req_we_i),
        .b_req_wrdata_i(b_req_wrdata_i), .b_rsp_valid_o(b_rsp_valid_o),
        .b_rsp_rddata_o(b_rsp_rddata_o),
        .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_addr_o(bram_addr_o),
        .bram_wrdata_o(bram_wrdata_o), .bram_rddata_i(bram_rddata_i),
        .conflict_cnt_o(conflict_cnt_o)
    );

    // Bank memories with an RD_LAT-deep registered read path.
    logic [DW-1:0] bmem  [BANKS][DEPTH];
    logic [DW-1:0] rpipe [BANKS][RD_LAT];

    always @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            for (int s = 1; s < RD_LAT; s++) rpipe[b][s] <= rpipe[b][s-1];
            if (bram_en_o[b]) begin
                if (bram_we_o[b*WEW +: WEW] == '0)
                    rpipe[b][0] <= bmem[b][bram_addr_o[b*OA +: OA]];
                for (int j = 0; j < WEW; j++)
                    if (bram_we_o[b*WEW + j])
                        bmem[b][bram_addr_o[b*OA +: OA]][8*j +: 8] <= bram_wrdata_o[b*DW + 8*j +: 8];
            end
        end
    end

    always_comb begin
        bram_rddata_i = '0;
        for (int b = 0; b < BANKS; b++) bram_rddata_i[b*DW +: DW] = rpipe[b][RD_LAT-1];
    end

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cycle    = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference: one flat word-addressed memory, arbitration by the stated rules.
    typedef struct { longint due; logic [DW-1:0] data; } exp_t;
    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] ref_mem [1 << IA];
    bit            m_prio = 1'b0;
    int            m_cnt  = 0;

    initial begin
        for (int a = 0; a < (1 << IA); a++) ref_mem[a] = '0;
        for (int b = 0; b < BANKS; b++) begin
            for (int w = 0; w < DEPTH; w++) bmem[b][w] = '0;
            for (int s = 0; s < RD_LAT; s++) rpipe[b][s] = '0;
        end
    end

    task automatic ref_write(input logic [IA-1:0] addr, input logic [WEW-1:0] we, input logic [DW-1:0] d);
        for (int j = 0; j < WEW; j++)
            if (we[j]) ref_mem[addr][8*j +: 8] = d[8*j +: 8];
    endtask

    always @(negedge clk) begin : model
        int ba, bb;
        bit ga, gb, conf;
        logic [BANKS-1:0]     e_en;
        logic [BANKS*WEW-1:0] e_we;
        logic [BANKS*OA-1:0]  e_addr;
        logic [BANKS*DW-1:0]  e_wd;
        if (rst) begin
            chk("rst_ready", {62'd0, a_req_ready_o, b_req_ready_o}, 64'd0);
            chk("rst_bram_en_we", {52'd0, bram_en_o, bram_we_o}, 64'd0);
            chk("rst_bram_addr", {32'd0, bram_addr_o}, 64'd0);
            chk("rst_bram_wrdata", bram_wrdata_o, 64'd0);
            m_prio = 1'b0;
            m_cnt  = 0;
            qa.delete();
            qb.delete();
        end else begin
            ba   = int'(a_req_addr_i) % BANKS;
            bb   = int'(b_req_addr_i) % BANKS;
            conf = a_req_valid_i && b_req_valid_i && (ba == bb);
            ga   = a_req_valid_i && (!conf || !m_prio);
            gb   = b_req_valid_i && (!conf || m_prio);
            chk("a_ready", {63'd0, a_req_ready_o}, {63'd0, ga});
            chk("b_ready", {63'd0, b_req_ready_o}, {63'd0, gb});
            chk("conflict_cnt", {48'd0, conflict_cnt_o}, 64'(m_cnt));
            e_en = '0; e_we = '0; e_addr = '0; e_wd = '0;
            if (ga) begin
                e_en[ba] = 1'b1;
                e_we[ba*WEW +: WEW] = a_req_we_i;
                e_addr[ba*OA +: OA] = OA'(int'(a_req_addr_i) / BANKS);
                e_wd[ba*DW +: DW]   = a_req_wrdata_i;
            end
            if (gb) begin
                e_en[bb] = 1'b1;
                e_we[bb*WEW +: WEW] = b_req_we_i;
                e_addr[bb*OA +: OA] = OA'(int'(b_req_addr_i) / BANKS);
                e_wd[bb*DW +: DW]   = b_req_wrdata_i;
            end
            chk("bram_en", {60'd0, bram_en_o}, {60'd0, e_en});
            chk("bram_we", {56'd0, bram_we_o}, {56'd0, e_we});
            chk("bram_addr", {32'd0, bram_addr_o}, {32'd0, e_addr});
            chk("bram_wrdata", bram_wrdata_o, e_wd);
            if (ga && a_req_we_i == '0) qa.push_back('{cycle + RD_LAT, ref_mem[a_req_addr_i]});
            if (gb && b_req_we_i == '0) qb.push_back('{cycle + RD_LAT, ref_mem[b_req_addr_i]});
            if (ga) ref_write(a_req_addr_i, a_req_we_i, a_req_wrdata_i);
            if (gb) ref_write(b_req_addr_i, b_req_we_i, b_req_wrdata_i);
            if (conf) begin
                m_prio = !m_prio;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
        end
    end

    task automatic check_rsp(input bit is_b, input logic v, input logic [DW-1:0] d);
        exp_t e;
        bit   due_now;
        due_now = 1'b0;
        if (!is_b && qa.size() > 0 && qa[0].due == cycle) begin e = qa.pop_front(); due_now = 1'b1; end
        if ( is_b && qb.size() > 0 && qb[0].due == cycle) begin e = qb.pop_front(); due_now = 1'b1; end
        if (due_now) begin
            chk(is_b ? "b_rsp_valid" : "a_rsp_valid", {63'd0, v}, 64'd1);
            chk(is_b ? "b_rsp_data"  : "a_rsp_data",  {48'd0, d}, {48'd0, e.data});
        end else begin
            chk(is_b ? "b_rsp_idle"      : "a_rsp_idle",      {63'd0, v}, 64'd0);
            chk(is_b ? "b_rsp_idle_data" : "a_rsp_idle_data", {48'd0, d}, 64'd0);
        end
    endtask

    always @(negedge clk) begin : monitor
        if (rst) begin
            chk("rst_a_rsp", {47'd0, a_rsp_valid_o, a_rsp_rddata_o}, 64'd0);
            chk("rst_b_rsp", {47'd0, b_rsp_valid_o, b_rsp_rddata_o}, 64'd0);
        end else begin
            check_rsp(1'b0, a_rsp_valid_o, a_rsp_rddata_o);
            check_rsp(1'b1, b_rsp_valid_o, b_rsp_rddata_o);
        end
    end

    task automatic set_a(input logic v, input int addr, input logic [WEW-1:0] we, input logic [DW-1:0] d);
        a_req_valid_i = v; a_req_addr_i = IA'(addr); a_req_we_i = we; a_req_wrdata_i = d;
    endtask

    task automatic set_b(input logic v, input int addr, input logic [WEW-1:0] we, input logic [DW-1:0] d);
        b_req_valid_i = v; b_req_addr_i = IA'(addr); b_req_we_i = we; b_req_wrdata_i = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_a(1'b0, 0, '0, '0);
        set_b(1'b0, 0, '0, '0);
        repeat (n) step();
    endtask

    task automatic rand_req(input bit is_b);
        logic          v;
        int            addr;
        logic [WEW-1:0] we;
        v    = ($urandom_range(0, 9) < 7);
        addr = int'($urandom_range(0, 31));
        we   = ($urandom_range(0, 1) == 0) ? WEW'(0) : WEW'($urandom_range(1, 3));
        if (is_b) set_b(v, addr, we, DW'($urandom));
        else      set_a(v, addr, we, DW'($urandom));
    endtask

    initial begin : stimulus
        bit a_took, b_took;
        int nv;
        repeat (3) step();
        rst = 1'b0;

        // Two reads to distinct banks in one cycle.
        set_a(1'b1, 'h005, '0, '0);
        set_b(1'b1, 'h00A, '0, '0);
        @(negedge clk);
        chk("dual_bank_en", {60'd0, bram_en_o}, 64'b0110);
        chk("dual_ready", {62'd0, a_req_ready_o, b_req_ready_o}, 64'b11);
        step();

        // Partial byte write to bank 0.
        set_a(1'b1, 'h010, 2'b01, 16'hBEEF);
        set_b(1'b0, 0, '0, '0);
        @(negedge clk);
        chk("wr_en_bank0", {63'd0, bram_en_o[0]}, 64'd1);
        chk("wr_we_bank0", {62'd0, bram_we_o[1:0]}, 64'b01);
        chk("wr_addr_bank0", {56'd0, bram_addr_o[7:0]}, 64'h04);
        step();
        idle(RD_LAT + 1);

        // Fill low memory with known data.
        for (int k = 0; k < 128; k++) begin
            set_a(1'b1, k, 2'b11, DW'($urandom));
            step();
        end
        idle(RD_LAT + 1);

        // Repeated same-bank reads: grants must alternate starting with A.
        set_a(1'b1, 3, '0, '0);
        set_b(1'b1, 7, '0, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_a_grant", {63'd0, a_req_ready_o}, {63'd0, (k % 2 == 0)});
            chk("alt_b_grant", {63'd0, b_req_ready_o}, {63'd0, (k % 2 == 1)});
            step();
        end
        set_a(1'b0, 0, '0, '0);
        set_b(1'b0, 0, '0, '0);
        @(negedge clk);
        chk("alt_conflict_cnt", {48'd0, conflict_cnt_o}, 64'd4);
        idle(RD_LAT + 2);

        // Streamed reads from A must come back as consecutive responses.
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            set_a(1'b1, k, '0, '0);
            @(negedge clk);
            nv += int'(a_rsp_valid_o);
            step();
        end
        set_a(1'b0, 0, '0, '0);
        for (int k = 0; k < RD_LAT + 1; k++) begin
            @(negedge clk);
            nv += int'(a_rsp_valid_o);
            step();
        end
        chk("stream_rsp_count", 64'(nv), 64'd8);
        idle(2);

        // Reset one cycle after a read is accepted discards it.
        set_a(1'b1, 3, '0, '0);
        step();
        set_a(1'b0, 0, '0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_a(1'b1, 0, '0, '0);
        set_b(1'b1, 4, '0, '0);
        @(negedge clk);
        chk("post_rst_a_wins", {62'd0, a_req_ready_o, b_req_ready_o}, 64'b10);
        chk("post_rst_cnt", {48'd0, conflict_cnt_o}, 64'd0);
        step();
        idle(RD_LAT + 2);

        // Random traffic; requests are held until accepted.
        rand_req(1'b0);
        rand_req(1'b1);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            a_took = a_req_valid_i && a_req_ready_o;
            b_took = b_req_valid_i && b_req_ready_o;
            step();
            if (!a_req_valid_i || a_took) rand_req(1'b0);
            if (!b_req_valid_i || b_took) rand_req(1'b1);
        end
        idle(RD_LAT + 2);

        // Saturate the collision counter.
        set_a(1'b1, 2, '0, '0);
        set_b(1'b1, 6, '0, '0);
        repeat (70000) step();
        set_a(1'b0, 0, '0, '0);
        set_b(1'b0, 0, '0, '0);
        @(negedge clk);
        chk("cnt_saturated", {48'd0, conflict_cnt_o}, 64'hFFFF);
        idle(RD_LAT + 3);

        @(negedge clk);
        chk("drain_a", 64'(qa.size()), 64'd0);
        chk("drain_b", 64'(qb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bram_bank_arbiter
`default_nettype wire
